// File: rtl/freq_counter.sv
// Symbol frequency counter: builds a 256-entry histogram of the input
// stream, then emits each nonzero (ascii, freq) pair in ascending order.
module freq_counter #(
  parameter int FREQ_W = 32
) (
  input  logic              clk,
  input  logic              ctrl_reset,
  input  logic              ctrl_start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_byte,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_ascii,
  output logic [FREQ_W-1:0] out_freq,
  output logic              out_last,
  output logic [8:0]        symCount,
  output logic              done
);

  typedef enum logic [2:0] {
    CLEAR,
    COUNT,
    SCAN,
    EMIT,
    DONE
  } state_t;

  localparam logic [FREQ_W-1:0] ONE = {{(FREQ_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [7:0]        ptr_q, ptr_d;
  logic [7:0]        max_q, max_d;
  logic [8:0]        sym_q, sym_d;
  logic              ov_q, ov_d;
  logic              ol_q, ol_d;
  logic [7:0]        oa_q, oa_d;
  logic [FREQ_W-1:0] of_q, of_d;

  logic [FREQ_W-1:0] tbl_q [256];

  logic              wr_en;
  logic [7:0]        wr_addr;
  logic [FREQ_W-1:0] wr_data;

  logic [FREQ_W-1:0] cur;
  logic [FREQ_W-1:0] scan_val;
  logic              in_xfer;
  logic              out_xfer;

  assign cur      = tbl_q[in_byte];
  assign scan_val = tbl_q[ptr_q];
  assign in_xfer  = in_valid && (state_q == COUNT);
  assign out_xfer = ov_q && out_ready;

  // Next-state, table write port and output register updates
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    max_d   = max_q;
    sym_d   = sym_q;
    ov_d    = ov_q;
    ol_d    = ol_q;
    oa_d    = oa_q;
    of_d    = of_q;
    wr_en   = 1'b0;
    wr_addr = ptr_q;
    wr_data = '0;
    unique case (state_q)
      CLEAR: begin
        wr_en = 1'b1;
        ptr_d = ptr_q + 8'd1;
        if (ptr_q == 8'hFF) begin
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (in_xfer) begin
          wr_en   = 1'b1;
          wr_addr = in_byte;
          wr_data = (&cur) ? cur : cur + ONE;
          if (cur == '0) begin
            sym_d = sym_q + 9'd1;
          end
          if (in_byte > max_q) begin
            max_d = in_byte;
          end
          if (in_last) begin
            state_d = SCAN;
            ptr_d   = 8'd0;
          end
        end
      end
      SCAN: begin
        if (scan_val != '0) begin
          oa_d    = ptr_q;
          of_d    = scan_val;
          ol_d    = (ptr_q == max_q);
          ov_d    = 1'b1;
          state_d = EMIT;
        end else begin
          ptr_d = ptr_q + 8'd1;
        end
      end
      EMIT: begin
        if (out_xfer) begin
          ov_d = 1'b0;
          ol_d = 1'b0;
          if (ol_q) begin
            state_d = DONE;
          end else begin
            ptr_d   = ptr_q + 8'd1;
            state_d = SCAN;
          end
        end
      end
      DONE: begin
        if (ctrl_start) begin
          state_d = CLEAR;
          ptr_d   = 8'd0;
          sym_d   = 9'd0;
          max_d   = 8'd0;
        end
      end
      default: begin
        state_d = CLEAR;
        ptr_d   = 8'd0;
      end
    endcase
  end

  // Control and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      state_q <= CLEAR;
      ptr_q   <= 8'd0;
      max_q   <= 8'd0;
      sym_q   <= 9'd0;
      ov_q    <= 1'b0;
      ol_q    <= 1'b0;
      oa_q    <= 8'd0;
      of_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      max_q   <= max_d;
      sym_q   <= sym_d;
      ov_q    <= ov_d;
      ol_q    <= ol_d;
      oa_q    <= oa_d;
      of_q    <= of_d;
    end
  end

  // Histogram storage; zeroed by the CLEAR sweep rather than by reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tbl_q[wr_addr] <= wr_data;
    end
  end

  assign in_ready  = (state_q == COUNT);
  assign done      = (state_q == DONE);
  assign out_valid = ov_q;
  assign out_last  = ol_q;
  assign out_ascii = oa_q;
  assign out_freq  = of_q;
  assign symCount  = sym_q;

endmodule

// File: tb/tb_freq_counter.sv
// Directed bench for freq_counter: histogram build, ordered emit,
// backpressure, saturation, scan latency and mid-emit reset.
module tb_freq_counter;

  logic        clk = 1'b0;
  logic        ctrl_reset;
  logic        ctrl_start;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_byte;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_ascii;
  logic [31:0] out_freq;
  logic        out_last;
  logic [8:0]  symCount;
  logic        done;

  logic        b_start;
  logic        b_valid;
  logic        b_ready;
  logic [7:0]  b_byte;
  logic        b_last;
  logic        b_ovalid;
  logic        b_oready;
  logic [7:0]  b_ascii;
  logic [3:0]  b_freq;
  logic        b_olast;
  logic [8:0]  b_sym;
  logic        b_done;

  int tests = 0;
  int fails = 0;
  int n;
  int cyc;

  always #5 clk = ~clk;

  freq_counter #(.FREQ_W(32)) dut (
    .clk(clk), .ctrl_reset(ctrl_reset), .ctrl_start(ctrl_start),
    .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_ascii(out_ascii), .out_freq(out_freq), .out_last(out_last),
    .symCount(symCount), .done(done)
  );

  freq_counter #(.FREQ_W(4)) dut4 (
    .clk(clk), .ctrl_reset(ctrl_reset), .ctrl_start(b_start),
    .in_valid(b_valid), .in_ready(b_ready), .in_byte(b_byte),
    .in_last(b_last), .out_valid(b_ovalid), .out_ready(b_oready),
    .out_ascii(b_ascii), .out_freq(b_freq), .out_last(b_olast),
    .symCount(b_sym), .done(b_done)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic l);
    in_valid = 1'b1;
    in_byte  = b;
    in_last  = l;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_ready(input string tag, output int cnt);
    cnt = 0;
    while (!in_ready && cnt < 400) begin
      @(posedge clk); #1;
      cnt++;
    end
    check(tag, in_ready, 1'b1);
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!out_valid && k < 600) begin
      @(posedge clk); #1;
      k++;
    end
    check(tag, out_valid, 1'b1);
  endtask

  task automatic beat(input string tag, input logic [7:0] a,
                      input logic [31:0] f, input logic l);
    out_ready = 1'b1;
    wait_valid({tag, "_valid"});
    check({tag, "_ascii"}, out_ascii, a);
    check({tag, "_freq"}, out_freq, f);
    check({tag, "_last"}, out_last, l);
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic restart();
    ctrl_start = 1'b1;
    @(posedge clk); #1;
    ctrl_start = 1'b0;
    check("start_sym_clr", symCount, 9'd0);
    check("start_not_done", done, 1'b0);
    wait_ready("start_ready", n);
  endtask

  initial begin
    ctrl_reset = 1'b1;
    ctrl_start = 1'b0;
    in_valid   = 1'b0;
    in_byte    = 8'd0;
    in_last    = 1'b0;
    out_ready  = 1'b0;
    b_start    = 1'b0;
    b_valid    = 1'b0;
    b_byte     = 8'd0;
    b_last     = 1'b0;
    b_oready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    ctrl_reset = 1'b0;

    // reset state and 256-cycle clear sweep
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sym", symCount, 9'd0);
    check("rst_out_freq", out_freq, 32'd0);
    wait_ready("clr_ready", n);
    check("clr_cycles", n, 256);

    // 4-bit counts saturate at 15
    check("sat_ready", b_ready, 1'b1);
    for (int i = 0; i < 20; i++) begin
      b_valid = 1'b1;
      b_byte  = 8'h00;
      b_last  = (i == 19);
      @(posedge clk); #1;
    end
    b_valid  = 1'b0;
    b_last   = 1'b0;
    b_oready = 1'b1;
    n = 0;
    while (!b_ovalid && n < 600) begin
      @(posedge clk); #1;
      n++;
    end
    check("sat_valid", b_ovalid, 1'b1);
    check("sat_ascii", b_ascii, 8'h00);
    check("sat_freq", b_freq, 4'd15);
    check("sat_last", b_olast, 1'b1);
    check("sat_sym", b_sym, 9'd1);
    @(posedge clk); #1;
    b_oready = 1'b0;
    check("sat_done", b_done, 1'b1);
    check("sat_drop", b_ovalid, 1'b0);

    // basic two-symbol stream
    send(8'h41, 1'b0);
    send(8'h42, 1'b0);
    send(8'h41, 1'b1);
    check("ab_ready_low", in_ready, 1'b0);
    beat("ab0", 8'h41, 32'd2, 1'b0);
    beat("ab1", 8'h42, 32'd1, 1'b1);
    check("ab_sym", symCount, 9'd2);
    check("ab_done", done, 1'b1);

    // start is ignored outside DONE; then the same stream under backpressure
    restart();
    ctrl_start = 1'b1;
    send(8'h41, 1'b0);
    ctrl_start = 1'b0;
    send(8'h42, 1'b0);
    send(8'h41, 1'b1);
    wait_valid("bp_first");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", out_valid, 1'b1);
      check("bp_hold_ascii", out_ascii, 8'h41);
      check("bp_hold_freq", out_freq, 32'd2);
    end
    beat("bp0", 8'h41, 32'd2, 1'b0);
    beat("bp1", 8'h42, 32'd1, 1'b1);
    check("bp_sym", symCount, 9'd2);
    check("bp_done", done, 1'b1);

    // scan latency for the highest symbol: cycle count with the
    // in_last transfer cycle as 0
    restart();
    send(8'hFF, 1'b1);
    cyc = 1;
    while (!out_valid && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("ff_latency", cyc, 257);
    beat("ff", 8'hFF, 32'd1, 1'b1);
    check("ff_sym", symCount, 9'd1);

    // reset during EMIT
    restart();
    send(8'h20, 1'b1);
    wait_valid("ar_emit");
    #2;
    ctrl_reset = 1'b1;
    #1;
    check("ar_valid_low", out_valid, 1'b0);
    check("ar_ready_low", in_ready, 1'b0);
    check("ar_sym", symCount, 9'd0);
    check("ar_ascii", out_ascii, 8'h00);
    @(posedge clk); #1;
    ctrl_reset = 1'b0;
    wait_ready("ar_clr", n);
    check("ar_clr_cycles", n, 256);
    send(8'h10, 1'b1);
    beat("ar_new", 8'h10, 32'd1, 1'b1);
    check("ar_new_sym", symCount, 9'd1);
    check("ar_new_done", done, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
